// File: rtl/tri_chk_pkg.sv
// Shared types and helpers for the three-implementation response checker.
// Holds the FSM state encoding, default widths and the bitwise majority vote.
package tri_chk_pkg;

    localparam int unsigned DEF_OUT_W      = 2;
    localparam int unsigned DEF_SETTLE_CYC = 4;
    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_IDX_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_SETTLE  = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/maj3_cmp.sv
// Combinational majority vote across three implementation outputs.
// Ports: y_sw/y_as/y_gt (OUT_W each) in; mask {gt,as,sw} out, set where an impl differs from majority.
module maj3_cmp
    import tri_chk_pkg::*;
#(
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic [OUT_W-1:0] y_sw,
    input  logic [OUT_W-1:0] y_as,
    input  logic [OUT_W-1:0] y_gt,
    output logic [2:0]       mask
);

    logic [OUT_W-1:0] w_maj;

    always_comb begin
        w_maj = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            w_maj[i] = maj3(y_sw[i], y_as[i], y_gt[i]);
        end
    end

    assign mask = {|(y_gt ^ w_maj), |(y_as ^ w_maj), |(y_sw ^ w_maj)};

endmodule

// File: rtl/tri_impl_response_checker.sv
// Samples three implementations after a settle window, votes, counts disagreements.
// Ports: start/vec_* handshake in, y_sw/y_as/y_gt in; mismatch, mask, err_cnt, first_err_*, done, pass out.
module tri_impl_response_checker
    import tri_chk_pkg::*;
#(
    parameter int unsigned OUT_W      = DEF_OUT_W,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned IDX_W      = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [IDX_W-1:0] vec_idx,
    input  logic             vec_last,
    output logic             vec_ready,
    input  logic [OUT_W-1:0] y_sw,
    input  logic [OUT_W-1:0] y_as,
    input  logic [OUT_W-1:0] y_gt,
    output logic             mismatch,
    output logic [2:0]       mismatch_mask,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [IDX_W-1:0] first_err_idx,
    output logic             done,
    output logic             pass
);

    localparam int unsigned SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [SC_W-1:0]  r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_last;
    logic             r_mismatch;
    logic [2:0]       r_mask;
    logic [CNT_W-1:0] r_err;
    logic             r_fvld;
    logic [IDX_W-1:0] r_fidx;
    logic             r_done;
    logic             r_pass;

    logic [2:0]       w_mask;
    logic             w_mis;
    logic [CNT_W-1:0] w_err_next;

    maj3_cmp #(.OUT_W(OUT_W)) u_vote (
        .y_sw (y_sw),
        .y_as (y_as),
        .y_gt (y_gt),
        .mask (w_mask)
    );

    assign w_mis = |w_mask;
    // Counter sticks at all-ones once reached.
    assign w_err_next = (w_mis && (r_err != CNT_MAX)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_mismatch <= 1'b0;
            r_mask     <= '0;
            r_err      <= '0;
            r_fvld     <= 1'b0;
            r_fidx     <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            // start aborts whatever is in flight, including a pending vector.
            if (start) begin
                r_state <= S_ARMED;
                r_cnt   <= '0;
                r_mask  <= '0;
                r_err   <= '0;
                r_fvld  <= 1'b0;
                r_fidx  <= '0;
                r_done  <= 1'b0;
                r_pass  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                    end
                    S_ARMED: begin
                        if (vec_valid) begin
                            r_idx   <= vec_idx;
                            r_last  <= vec_last;
                            r_cnt   <= SC_LOAD;
                            r_state <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == '0) begin
                            r_state <= S_COMPARE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_COMPARE: begin
                        r_mask     <= w_mask;
                        r_mismatch <= w_mis;
                        r_err      <= w_err_next;
                        if (w_mis && !r_fvld) begin
                            r_fvld <= 1'b1;
                            r_fidx <= r_idx;
                        end
                        if (r_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_state <= S_ARMED;
                        end
                    end
                    S_DONE: begin
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign vec_ready     = (r_state == S_ARMED);
    assign mismatch      = r_mismatch;
    assign mismatch_mask = r_mask;
    assign err_cnt       = r_err;
    assign first_err_vld = r_fvld;
    assign first_err_idx = r_fidx;
    assign done          = r_done;
    assign pass          = r_pass;

endmodule
